// File: rtl/hls_ram_responder_if.sv
// Kernel/debug RAM port bundle for hls_ram_responder.
// master drives addresses and writes; slave returns data and status.
interface hls_ram_responder_if #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] raddr_0;
  logic [WIDTH-1:0]      rdata_0;
  logic [ADDR_WIDTH-1:0] waddr_0;
  logic [WIDTH-1:0]      wdata_0;
  logic                  wen_0;
  logic [ADDR_WIDTH-1:0] debug_addr;
  logic [WIDTH-1:0]      debug_data;
  logic [ADDR_WIDTH-1:0] debug_write_addr;
  logic [WIDTH-1:0]      debug_write_data;
  logic                  debug_write_en;
  logic                  clear;
  logic                  busy;
  logic                  done;
  logic                  collision;

  modport master (
    output raddr_0, waddr_0, wdata_0, wen_0,
    output debug_addr, debug_write_addr,
    output debug_write_data, debug_write_en,
    output clear,
    input  rdata_0, debug_data,
    input  busy, done, collision
  );

  modport slave (
    input  raddr_0, waddr_0, wdata_0, wen_0,
    input  debug_addr, debug_write_addr,
    input  debug_write_data, debug_write_en,
    input  clear,
    output rdata_0, debug_data,
    output busy, done, collision
  );
endinterface

// File: rtl/hls_ram_responder.sv
// Dual-port (kernel + debug) RAM target for HLS kernels.
// Write-first registered reads, kernel-wins writes, sequential clear.
module hls_ram_responder #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 2**ADDR_WIDTH
) (
  input  logic clk,
  input  logic rst,
  hls_ram_responder_if.slave bus
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] LIMIT = CW'(DEPTH);
  localparam logic [CW-1:0] LAST  = CW'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    DONE
  } state_t;

  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;

  logic [WIDTH-1:0] mem [DEPTH];

  logic                  clearing;
  logic                  k_we;
  logic                  d_we;
  logic                  c_we;
  logic                  same;
  logic [ADDR_WIDTH-1:0] c_addr;
  logic [WIDTH-1:0]      rd_n;
  logic [WIDTH-1:0]      dd_n;

  function automatic logic in_range(
    input logic [ADDR_WIDTH-1:0] a
  );
    return {1'b0, a} < LIMIT;
  endfunction

  assign clearing = (state == CLEAR);
  assign c_addr   = cnt[ADDR_WIDTH-1:0];
  assign same     = (bus.debug_write_addr == bus.waddr_0);

  // Writes are gated by rst so a reset cycle never disturbs the array.
  assign k_we = rst && !clearing && bus.wen_0
             && in_range(bus.waddr_0);
  assign d_we = rst && !clearing && bus.debug_write_en
             && in_range(bus.debug_write_addr)
             && !(k_we && same);
  assign c_we = rst && clearing;

  // Sources are mutually exclusive: debug loses to kernel on a tie.
  function automatic logic [WIDTH-1:0] fwd(
    input logic [ADDR_WIDTH-1:0] a
  );
    logic [WIDTH-1:0] v;
    v = '0;
    unique case (1'b1)
      !in_range(a):
        v = '0;
      k_we && (bus.waddr_0 == a):
        v = bus.wdata_0;
      d_we && (bus.debug_write_addr == a):
        v = bus.debug_write_data;
      c_we && (c_addr == a):
        v = '0;
      default:
        v = mem[a];
    endcase
    return v;
  endfunction

  always_comb begin
    rd_n = fwd(bus.raddr_0);
    dd_n = fwd(bus.debug_addr);
  end

  always_ff @(posedge clk) begin
    if (k_we) mem[bus.waddr_0] <= bus.wdata_0;
    if (d_we) mem[bus.debug_write_addr] <= bus.debug_write_data;
    if (c_we) mem[c_addr] <= '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      bus.rdata_0    <= '0;
      bus.debug_data <= '0;
      bus.collision  <= 1'b0;
    end else begin
      bus.rdata_0    <= rd_n;
      bus.debug_data <= dd_n;
      bus.collision  <= k_we && bus.debug_write_en && same;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      IDLE, DONE: begin
        state_n = IDLE;
        if (bus.clear) begin
          state_n = CLEAR;
          cnt_n   = '0;
        end
      end
      CLEAR: begin
        cnt_n = cnt + 1'b1;
        if (cnt == LAST) state_n = DONE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.busy = clearing;
  assign bus.done = (state == DONE);

endmodule

// File: tb/tb_hls_ram_responder.sv
// Bench for hls_ram_responder: array-level reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_hls_ram_responder;

  localparam int W  = 32;
  localparam int AW = 8;
  localparam int D  = 256;
  localparam int D2 = 200;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  hls_ram_responder_if #(.WIDTH(W), .ADDR_WIDTH(AW)) bus ();
  hls_ram_responder_if #(.WIDTH(W), .ADDR_WIDTH(AW)) bus2 ();

  hls_ram_responder #(
    .WIDTH(W), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  hls_ram_responder #(
    .WIDTH(W), .ADDR_WIDTH(AW), .DEPTH(D2)
  ) dut2 (
    .clk(clk), .rst(rst), .bus(bus2)
  );

  int n_chk  = 0;
  int n_fail = 0;

  function automatic void chk(
    input string name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h",
               name, act, exp);
    end
  endfunction

  // Reference model: an array plus a clear countdown.
  logic [31:0] ref_mem [D];
  bit          known   [D];
  logic [31:0] e_rd, e_dd;
  bit          e_rd_k, e_dd_k;
  bit          e_busy, e_done, e_coll;
  bit          m_clr;
  int          m_idx;
  bit          m_valid = 1'b0;
  bit          kin;
  int          ra, da, wa, dwa;

  initial begin
    for (int i = 0; i < D; i++) known[i] = 1'b0;
    forever begin
      @(posedge clk);
      if (!rst) begin
        e_rd = 0; e_dd = 0;
        e_rd_k = 1; e_dd_k = 1;
        e_busy = 0; e_done = 0; e_coll = 0;
        m_clr = 0;
      end else begin
        e_coll = 0;
        e_done = 0;
        wa  = int'(bus.waddr_0);
        dwa = int'(bus.debug_write_addr);
        if (m_clr) begin
          ref_mem[m_idx] = 0;
          known[m_idx] = 1;
          m_idx++;
          if (m_idx == D) begin
            m_clr  = 0;
            e_done = 1;
          end
        end else begin
          kin = bus.wen_0 && wa < D;
          if (kin) begin
            ref_mem[wa] = bus.wdata_0;
            known[wa] = 1;
          end
          if (bus.debug_write_en && dwa < D) begin
            if (kin && dwa == wa) e_coll = 1;
            else begin
              ref_mem[dwa] = bus.debug_write_data;
              known[dwa] = 1;
            end
          end
          if (bus.clear) begin
            m_clr = 1;
            m_idx = 0;
          end
        end
        e_busy = m_clr;
        ra = int'(bus.raddr_0);
        da = int'(bus.debug_addr);
        e_rd_k = (ra >= D) || known[ra];
        e_rd   = (ra >= D) ? 32'h0 : ref_mem[ra];
        e_dd_k = (da >= D) || known[da];
        e_dd   = (da >= D) ? 32'h0 : ref_mem[da];
      end
      m_valid = 1'b1;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (m_valid) begin
        if (e_rd_k) chk("m_rdata_0", bus.rdata_0, e_rd);
        if (e_dd_k) chk("m_debug_data", bus.debug_data, e_dd);
        chk("m_busy", 32'(bus.busy), 32'(e_busy));
        chk("m_done", 32'(bus.done), 32'(e_done));
        chk("m_collision", 32'(bus.collision), 32'(e_coll));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle();
    bus.raddr_0 = '0; bus.waddr_0 = '0;
    bus.wdata_0 = '0; bus.wen_0 = 1'b0;
    bus.debug_addr = '0; bus.debug_write_addr = '0;
    bus.debug_write_data = '0; bus.debug_write_en = 1'b0;
    bus.clear = 1'b0;
    bus2.raddr_0 = '0; bus2.waddr_0 = '0;
    bus2.wdata_0 = '0; bus2.wen_0 = 1'b0;
    bus2.debug_addr = '0; bus2.debug_write_addr = '0;
    bus2.debug_write_data = '0; bus2.debug_write_en = 1'b0;
    bus2.clear = 1'b0;
  endtask

  task automatic fill(input logic [31:0] base, input bit add_idx);
    for (int i = 0; i < D / 2; i++) begin
      bus.wen_0 = 1'b1;
      bus.waddr_0 = AW'(2 * i);
      bus.wdata_0 = add_idx ? (base | 32'(2 * i)) : base;
      bus.debug_write_en = 1'b1;
      bus.debug_write_addr = AW'(2 * i + 1);
      bus.debug_write_data = add_idx ? (base | 32'(2 * i + 1)) : base;
      tick();
    end
    idle();
  endtask

  int busy_n, first_busy, done_at, coll_n, dn;

  initial begin
    idle();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;

    // Bring both arrays to a known all-zero state.
    bus.clear = 1'b1;
    bus2.clear = 1'b1;
    tick();
    idle();
    repeat (258) tick();

    // Reset values; array contents survive reset.
    bus.wen_0 = 1'b1; bus.waddr_0 = 8'd3; bus.wdata_0 = 32'hA5;
    tick();
    bus.raddr_0 = '1; bus.waddr_0 = '1; bus.wdata_0 = '1;
    bus.wen_0 = 1'b1; bus.debug_addr = '1;
    bus.debug_write_addr = '1; bus.debug_write_data = '1;
    bus.debug_write_en = 1'b1; bus.clear = 1'b1;
    rst = 1'b0;
    tick();
    tick();
    chk("rst_rdata_0", bus.rdata_0, 32'h0);
    chk("rst_debug_data", bus.debug_data, 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_done", 32'(bus.done), 32'h0);
    chk("rst_collision", 32'(bus.collision), 32'h0);
    rst = 1'b1;
    idle();
    bus.raddr_0 = 8'd3; bus.debug_addr = 8'd3;
    tick();
    chk("retain_rdata", bus.rdata_0, 32'hA5);
    chk("retain_debug", bus.debug_data, 32'hA5);

    // Histogram read-modify-write with same-cycle forwarding.
    idle();
    bus.wen_0 = 1'b1; bus.waddr_0 = 8'd7; bus.wdata_0 = 32'd5;
    tick();
    idle();
    bus.raddr_0 = 8'd7;
    tick();
    chk("hist_first", bus.rdata_0, 32'd5);
    for (int i = 0; i < 3; i++) begin
      bus.wen_0 = 1'b1;
      bus.waddr_0 = 8'd7;
      bus.wdata_0 = bus.rdata_0 + 32'd1;
      bus.raddr_0 = 8'd7;
      tick();
      chk("hist_iter", bus.rdata_0, 32'(6 + i));
    end
    idle();
    bus.debug_addr = 8'd7;
    tick();
    chk("hist_final", bus.debug_data, 32'd8);

    // Same-address collision: kernel wins, one-cycle pulse.
    bus.wen_0 = 1'b1; bus.waddr_0 = 8'd4; bus.wdata_0 = 32'h11;
    bus.debug_write_en = 1'b1; bus.debug_write_addr = 8'd4;
    bus.debug_write_data = 32'h22;
    bus.raddr_0 = 8'd4; bus.debug_addr = 8'd4;
    tick();
    chk("coll_pulse", 32'(bus.collision), 32'h1);
    chk("coll_rdata", bus.rdata_0, 32'h11);
    chk("coll_debug", bus.debug_data, 32'h11);
    bus.wen_0 = 1'b0; bus.debug_write_en = 1'b0;
    tick();
    chk("coll_once", 32'(bus.collision), 32'h0);
    chk("coll_held", bus.rdata_0, 32'h11);
    bus.wen_0 = 1'b1; bus.waddr_0 = 8'd4; bus.wdata_0 = 32'h33;
    bus.debug_write_en = 1'b1; bus.debug_write_addr = 8'd5;
    bus.debug_write_data = 32'h44;
    bus.raddr_0 = 8'd4; bus.debug_addr = 8'd5;
    tick();
    chk("dual_nocoll", 32'(bus.collision), 32'h0);
    chk("dual_k", bus.rdata_0, 32'h33);
    chk("dual_d", bus.debug_data, 32'h44);
    idle();
    bus.raddr_0 = 8'd4; bus.debug_addr = 8'd5;
    tick();
    chk("dual_k_mem", bus.rdata_0, 32'h33);
    chk("dual_d_mem", bus.debug_data, 32'h44);

    // Full clear with writes attempted while busy.
    fill(32'hFFFF_FFFF, 1'b0);
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    busy_n = 0; first_busy = 0; done_at = 0; coll_n = 0;
    for (int c = 1; c <= 260; c++) begin
      if (bus.busy) busy_n++;
      if (bus.busy && first_busy == 0) first_busy = c;
      if (bus.done) done_at = c;
      if (bus.collision) coll_n++;
      bus.wen_0 = (c <= 250);
      bus.waddr_0 = 8'd10; bus.wdata_0 = 32'h1234;
      bus.debug_write_en = (c <= 250);
      bus.debug_write_addr = 8'd10;
      bus.debug_write_data = 32'h5678;
      tick();
    end
    idle();
    chk("clr_busy_cycles", 32'(busy_n), 32'd256);
    chk("clr_first_busy", 32'(first_busy), 32'd1);
    chk("clr_done_cycle", 32'(done_at), 32'd257);
    chk("clr_no_coll", 32'(coll_n), 32'd0);
    for (int a = 0; a < D; a++) begin
      bus.debug_addr = AW'(a);
      tick();
      chk("clr_read", bus.debug_data, 32'h0);
    end

    // Reset in cycle 100 of a clear.
    fill(32'h5A5A_0000, 1'b1);
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    repeat (99) tick();
    chk("mid_busy_before", 32'(bus.busy), 32'h1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("mid_busy_after", 32'(bus.busy), 32'h0);
    dn = 0;
    repeat (200) begin
      if (bus.done) dn++;
      tick();
    end
    chk("mid_no_done", 32'(dn), 32'h0);
    for (int a = 0; a < D; a++) begin
      bus.debug_addr = AW'(a);
      tick();
      if (a <= 98)
        chk("mid_cleared", bus.debug_data, 32'h0);
      else if (a >= 100)
        chk("mid_kept", bus.debug_data, 32'h5A5A_0000 | 32'(a));
    end
    idle();

    // DEPTH=200 instance: out-of-range and clear length.
    bus2.clear = 1'b1;
    tick();
    bus2.clear = 1'b0;
    busy_n = 0; done_at = 0;
    for (int c = 1; c <= 210; c++) begin
      if (bus2.busy) busy_n++;
      if (bus2.done) done_at = c;
      tick();
    end
    chk("oor_clr_cycles", 32'(busy_n), 32'd200);
    chk("oor_done_cycle", 32'(done_at), 32'd201);
    bus2.wen_0 = 1'b1; bus2.waddr_0 = 8'd250; bus2.wdata_0 = 32'h77;
    bus2.debug_write_en = 1'b1; bus2.debug_write_addr = 8'd250;
    bus2.debug_write_data = 32'h88;
    bus2.raddr_0 = 8'd250; bus2.debug_addr = 8'd250;
    tick();
    chk("oor_fwd_k", bus2.rdata_0, 32'h0);
    chk("oor_fwd_d", bus2.debug_data, 32'h0);
    bus2.debug_write_en = 1'b0;
    bus2.waddr_0 = 8'd199; bus2.wdata_0 = 32'h99;
    tick();
    bus2.wen_0 = 1'b0;
    bus2.raddr_0 = 8'd199; bus2.debug_addr = 8'd250;
    tick();
    chk("oor_last_entry", bus2.rdata_0, 32'h99);
    chk("oor_read_250", bus2.debug_data, 32'h0);
    bus2.raddr_0 = 8'd250;
    tick();
    chk("oor_kread_250", bus2.rdata_0, 32'h0);
    idle();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
